// File: rtl/axilite_vote_target_if.sv
// AXI4-Lite channel bundle between a voted master port and the vote target.
// Carries only the five AXI4-Lite channels; clock and reset stay outside.
interface axilite_vote_target_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axilite_vote_target.sv
// AXI4-Lite responder terminating the voted master port: four R/W registers plus
// committed-write and accepted-read counters, one outstanding response per channel.
module axilite_vote_target #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  axilite_vote_target_if.slave s_axi
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int SW     = DW / 8;
  localparam int N_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDX_REG0     = 3'd0,
    IDX_REG1     = 3'd1,
    IDX_REG2     = 3'd2,
    IDX_REG3     = 3'd3,
    IDX_WR_COUNT = 3'd4,
    IDX_RD_COUNT = 3'd5,
    IDX_HOLE6    = 3'd6,
    IDX_HOLE7    = 3'd7
  } word_idx_e;

  // Holding buffers for the independently accepted AW and W beats.
  logic          aw_full_q;
  logic [2:0]    aw_idx_q;
  logic          w_full_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;

  logic          awready_q;
  logic          wready_q;
  logic          arready_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic [DW-1:0] regs_q [N_REGS];
  logic [DW-1:0] wr_count_q;
  logic [DW-1:0] rd_count_q;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [2:0]    cmt_idx;
  logic [DW-1:0] cmt_data;
  logic [SW-1:0] cmt_strb;
  logic          cmt_mapped;
  logic          aw_full_d;
  logic          w_full_d;
  logic          bvalid_d;
  logic          rvalid_d;
  word_idx_e     rd_idx;
  logic          rd_mapped;
  logic [DW-1:0] rd_word;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    aw_hs      = s_axi.awvalid && awready_q;
    w_hs       = s_axi.wvalid && wready_q;
    ar_hs      = s_axi.arvalid && arready_q;

    // A beat arriving this edge is used directly, so commit needs no extra cycle.
    cmt_idx    = aw_full_q ? aw_idx_q : s_axi.awaddr[4:2];
    cmt_data   = w_full_q  ? w_data_q : s_axi.wdata;
    cmt_strb   = w_full_q  ? w_strb_q : s_axi.wstrb;
    cmt_mapped = !cmt_idx[2];
    commit     = (aw_full_q || aw_hs) && (w_full_q || w_hs);

    aw_full_d  = (aw_full_q || aw_hs) && !commit;
    w_full_d   = (w_full_q || w_hs) && !commit;
    bvalid_d   = commit || (bvalid_q && !s_axi.bready);
    rvalid_d   = ar_hs || (rvalid_q && !s_axi.rready);
  end

  always_comb begin
    rd_idx    = word_idx_e'(s_axi.araddr[4:2]);
    rd_word   = '0;
    rd_mapped = 1'b1;
    unique case (rd_idx)
      IDX_REG0, IDX_REG1,
      IDX_REG2, IDX_REG3:  rd_word = regs_q[rd_idx[1:0]];
      IDX_WR_COUNT:        rd_word = wr_count_q;
      IDX_RD_COUNT:        rd_word = rd_count_q;
      IDX_HOLE6, IDX_HOLE7: rd_mapped = 1'b0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values; this is what makes a same-edge read see the old register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      if (aw_hs) aw_idx_q <= s_axi.awaddr[4:2];
      if (w_hs) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      // Ready flags are registered from next-state so they never depend on inputs.
      awready_q <= !aw_full_d && !bvalid_d;
      wready_q  <= !w_full_d && !bvalid_d;
      bvalid_q  <= bvalid_d;
      if (commit) bresp_q <= cmt_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // NOTE: the register bank is only four words of flops, so it is reset along
  // with everything else; a RAM-style array would be left unreset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else if (commit && cmt_mapped) begin
      for (int k = 0; k < SW; k++) begin
        if (cmt_strb[k]) regs_q[cmt_idx[1:0]][8*k +: 8] <= cmt_data[8*k +: 8];
      end
      wr_count_q <= wr_count_q + 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_count_q <= '0;
    end else begin
      arready_q <= !rvalid_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
        if (rd_mapped) rd_count_q <= rd_count_q + 1'b1;
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

endmodule

// File: doc/axilite_vote_target.md
# axilite_vote_target

AXI4-Lite responder that terminates the voted master port (`M_AXI_out`) of the TMR voter. It holds a small bank of writable 32-bit registers and two read-only transaction counters, and it returns OKAY/SLVERR responses. It lets voter integration benches and on-chip self-tests check that exactly one voted transaction arrives per redundant triple.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; gives 8 word slots.

Ports (name, direction, width, meaning):
- S_AXI_ACLK  in  1  single clock; all logic on the rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  W handshake.
- S_AXI_BRESP  out  2  write response: 00 = OKAY, 10 = SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  B handshake.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  R handshake.

## Operation
Address map (word index = ADDR[4:2]; ADDR[1:0] ignored):
- 0x00–0x0C: REG0–REG3, read/write.
- 0x10: WR_COUNT, read-only. Counts committed OKAY writes; wraps 0xFFFFFFFF→0.
- 0x14: RD_COUNT, read-only. Counts accepted AR handshakes to mapped addresses; wraps.
- 0x18, 0x1C: unmapped.

Write path:
- AW and W are captured independently into single-entry holding buffers (aw_full, w_full).
- AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID.
- A write commits on the first edge at which both buffers hold data:
  - REGn bytes with WSTRB[k]=1 are updated.
  - BRESP=OKAY and WR_COUNT increments.
- A write to 0x10–0x1C has no register effect, BRESP=SLVERR, and WR_COUNT is unchanged.
- At commit both buffers clear and BVALID is set. BVALID is held with stable BRESP until BREADY.

Read path:
- ARREADY = !RVALID.
- On the AR handshake, RDATA/RRESP are registered from the current register state (pre-commit value if a write commits on the same edge). RVALID is then set and held stable until RREADY.
- Unmapped address: RDATA=0, RRESP=SLVERR, RD_COUNT unchanged.
- Reading RD_COUNT returns the value before its own increment.

Simultaneous events:
- Write commit and read of the same register on the same edge: the read returns the old value.
- Both counters may update on the same edge, independently.

Reset (asynchronous, any time):
- Clears all registers, counters, buffers, BVALID and RVALID.
- In-flight transactions are dropped; no response is issued after reset.

## Timing
- Reset values: all outputs 0, including AWREADY, WREADY and ARREADY.
- Ready flags are registered. They rise on the first rising edge after ARESETN deasserts, so they are first seen high in cycle 1.
- Write latency: AW and W handshaked in cycle N (same cycle or any order) → commit and BVALID=1 in cycle N+1 after the later of the two. Register contents are visible to a read handshaked in cycle N+1.
- Read latency: AR handshake in cycle N → RVALID=1 in cycle N+1.
- With BREADY and RREADY held high, sustained throughput is 1 write per 2 cycles and 1 read per 2 cycles.
- Write-response backpressure: AW/W are not accepted while BVALID=1, so at most one write response is outstanding.
- Read-response backpressure: AR is not accepted while RVALID=1, so at most one read response is outstanding.

## Test plan
- Reset release → all outputs 0 during reset; AWREADY=WREADY=ARREADY=1 in cycle 1.
- Write 0x00..0x0C with 1,2,3,4 (WSTRB=F), then read back the same addresses → RDATA 1,2,3,4 with OKAY, and WR_COUNT=4.
- W issued 3 cycles before AW to 0x04, data 0xAABBCCDD, WSTRB=0x5 over an old value of 0 → BVALID the cycle after the AW handshake; reading 0x04 returns 0x00BB00DD.
- Write to 0x10 → BRESP=SLVERR and WR_COUNT unchanged. Read 0x18 → RDATA=0, RRESP=SLVERR, and RD_COUNT unchanged.
- BREADY held low for 10 cycles after a write → BVALID/BRESP stable, AWREADY=WREADY=0 throughout. With RREADY low, RDATA stays stable and ARREADY=0.
- ARESETN pulsed low while BVALID=1 → BVALID drops immediately; after release REG0–REG3 and both counters read 0.
